// File: rtl/reg_transfer_sequencer.sv
// Sequencer for single register-to-register transfers and memory reads on the shared datapath bus.
// Drives the bus source select and the registered write-enable decoder (sel / EN_OP / EN_OUT).
module reg_transfer_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter logic [3:0]  MEM_SRC       = 4'b0010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_src,
  input  logic [3:0] req_dst,
  input  logic       req_mem,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic [3:0] bus_sel,
  output logic [3:0] wr_sel,
  output logic       wr_op_en,
  output logic       wr_out_en,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, WRITE, COMMIT, MEM_WAIT, ERROR
  } state_t;

  localparam logic [3:0] MDR_DST   = 4'b0101;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] src_q, src_d;
  logic [3:0] dst_q, dst_d;
  logic [3:0] scnt_q, scnt_d;
  logic [7:0] tcnt_q, tcnt_d;

  function automatic logic dst_legal(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: dst_legal = 1'b1;
      default:                                     dst_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    bus_sel   = '0;
    wr_sel    = '0;
    wr_op_en  = 1'b0;
    wr_out_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          src_d  = req_src;
          dst_d  = req_dst;
          scnt_d = '0;
          tcnt_d = '0;
          if (req_mem)                 state_d = MEM_WAIT;
          else if (!dst_legal(req_dst)) state_d = ERROR;
          else                         state_d = SETTLE;
        end
      end
      SETTLE: begin
        bus_sel = src_q;
        if (scnt_q == SETTLE_LAST) state_d = WRITE;
        else                       scnt_d  = scnt_q + 4'd1;
      end
      WRITE: begin
        bus_sel   = src_q;
        wr_sel    = dst_q;
        wr_op_en  = 1'b1;
        wr_out_en = 1'b1;
        state_d   = COMMIT;
      end
      COMMIT: begin
        bus_sel = src_q;
        wr_sel  = dst_q;
        done    = 1'b1;
        state_d = IDLE;
      end
      MEM_WAIT: begin
        mem_rd  = 1'b1;
        bus_sel = MEM_SRC;
        // ack is tested first so it wins over a coincident timeout
        if (mem_ack) begin
          src_d   = MEM_SRC;
          dst_d   = MDR_DST;
          scnt_d  = '0;
          state_d = SETTLE;
        end else if (tcnt_q == TMO_LAST) begin
          state_d = ERROR;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ERROR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed self-checking bench for reg_transfer_sequencer with default parameters.
module tb_reg_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src;
  logic [3:0] req_dst;
  logic       req_mem;
  logic       mem_ack;
  logic       mem_rd;
  logic [3:0] bus_sel;
  logic [3:0] wr_sel;
  logic       wr_op_en;
  logic       wr_out_en;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int mon_wr, mon_done, mon_err, mon_rd;

  always #5 clk = ~clk;

  reg_transfer_sequencer #(
    .SETTLE_CYCLES(1),
    .MEM_TIMEOUT  (15),
    .MEM_SRC      (4'b0010)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src  (req_src),
    .req_dst  (req_dst),
    .req_mem  (req_mem),
    .mem_ack  (mem_ack),
    .mem_rd   (mem_rd),
    .bus_sel  (bus_sel),
    .wr_sel   (wr_sel),
    .wr_op_en (wr_op_en),
    .wr_out_en(wr_out_en),
    .done     (done),
    .err      (err)
  );

  // Advance one edge, then sample and tally pulse outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_out_en) mon_wr++;
    if (done)      mon_done++;
    if (err)       mon_err++;
    if (mem_rd)    mon_rd++;
  endtask

  task automatic clear_mon();
    mon_wr = 0; mon_done = 0; mon_err = 0; mon_rd = 0;
  endtask

  // Packs {req_ready, mem_rd, bus_sel, wr_sel, wr_op_en, wr_out_en, done, err}
  function automatic logic [13:0] outs();
    return {req_ready, mem_rd, bus_sel, wr_sel, wr_op_en, wr_out_en, done, err};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; req_mem = 1'b0; mem_ack = 1'b0;
    clear_mon();
    tick(); tick();
    checks++;
    if (outs() !== 14'b1_0_0000_0000_0_0_0_0) begin
      errors++; $display("FAIL reset_outputs got %b want %b", outs(), 14'b1_0_0000_0000_0_0_0_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon();
    req_valid = 1'b1; req_src = 4'b1011; req_dst = 4'b0100; req_mem = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (outs() !== 14'b0_0_1011_0000_0_0_0_0) begin
      errors++; $display("FAIL basic_settle got %b want %b", outs(), 14'b0_0_1011_0000_0_0_0_0);
    end
    tick();
    checks++;
    if (outs() !== 14'b0_0_1011_0100_1_1_0_0) begin
      errors++; $display("FAIL basic_write got %b want %b", outs(), 14'b0_0_1011_0100_1_1_0_0);
    end
    tick();
    checks++;
    if (outs() !== 14'b0_0_1011_0100_0_0_1_0) begin
      errors++; $display("FAIL basic_commit got %b want %b", outs(), 14'b0_0_1011_0100_0_0_1_0);
    end
    tick();
    checks++;
    if (outs() !== 14'b1_0_0000_0000_0_0_0_0) begin
      errors++; $display("FAIL basic_idle got %b want %b", outs(), 14'b1_0_0000_0000_0_0_0_0);
    end
  endtask

  task automatic test_mem_read();
    clear_mon();
    req_valid = 1'b1; req_mem = 1'b1; req_src = 4'b1111; req_dst = 4'b0011;
    tick();
    req_valid = 1'b0; req_mem = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (outs() !== 14'b0_1_0010_0000_0_0_0_0) begin
        errors++; $display("FAIL mem_wait_%0d got %b want %b", k, outs(), 14'b0_1_0010_0000_0_0_0_0);
      end
      if (k == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    checks++;
    if (outs() !== 14'b0_0_0010_0000_0_0_0_0) begin
      errors++; $display("FAIL mem_settle got %b want %b", outs(), 14'b0_0_0010_0000_0_0_0_0);
    end
    tick();
    checks++;
    if (outs() !== 14'b0_0_0010_0101_1_1_0_0) begin
      errors++; $display("FAIL mem_write got %b want %b", outs(), 14'b0_0_0010_0101_1_1_0_0);
    end
    tick(); tick();
    checks++;
    if (mon_rd !== 4 || mon_done !== 1 || mon_wr !== 1 || mon_err !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mem_counts got rd=%0d done=%0d wr=%0d err=%0d ready=%b want rd=4 done=1 wr=1 err=0 ready=1",
               mon_rd, mon_done, mon_wr, mon_err, req_ready);
    end
  endtask

  task automatic test_mem_timeout();
    int n;
    clear_mon();
    req_valid = 1'b1; req_mem = 1'b1;
    tick();
    req_valid = 1'b0; req_mem = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_return got ready=%b want 1 within 40 cycles", req_ready);
    end
    checks++;
    if (mon_rd !== 15 || mon_err !== 1 || mon_wr !== 0 || mon_done !== 0 || n !== 16) begin
      errors++;
      $display("FAIL timeout_counts got rd=%0d err=%0d wr=%0d done=%0d cycles=%0d want rd=15 err=1 wr=0 done=0 cycles=16",
               mon_rd, mon_err, mon_wr, mon_done, n);
    end
  endtask

  task automatic test_illegal_dst();
    clear_mon();
    req_valid = 1'b1; req_src = 4'b0001; req_dst = 4'b0011; req_mem = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (outs() !== 14'b0_0_0000_0000_0_0_0_1) begin
      errors++; $display("FAIL illegal_err got %b want %b", outs(), 14'b0_0_0000_0000_0_0_0_1);
    end
    tick();
    checks++;
    if (outs() !== 14'b1_0_0000_0000_0_0_0_0 || mon_wr !== 0) begin
      errors++; $display("FAIL illegal_idle got %b wr=%0d want %b wr=0", outs(), mon_wr, 14'b1_0_0000_0000_0_0_0_0);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_mon();
    req_valid = 1'b1; req_src = 4'b0110; req_dst = 4'b1100; req_mem = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (wr_out_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_write got wr_out_en=%b want 1", wr_out_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== 14'b1_0_0000_0000_0_0_0_0) begin
      errors++; $display("FAIL rstmid_after got %b want %b", outs(), 14'b1_0_0000_0000_0_0_0_0);
    end
    clear_mon();
    req_valid = 1'b1; req_src = 4'b0111; req_dst = 4'b0001;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (outs() !== 14'b0_0_0111_0001_1_1_0_0) begin
      errors++; $display("FAIL rstmid_next_write got %b want %b", outs(), 14'b0_0_0111_0001_1_1_0_0);
    end
    tick(); tick();
    checks++;
    if (mon_done !== 1 || mon_wr !== 1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_next_done got done=%0d wr=%0d ready=%b want 1 1 1", mon_done, mon_wr, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_bus [8];
    logic       exp_rdy [8];
    exp_bus = '{4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_mon();
    req_valid = 1'b1; req_src = 4'b1001; req_dst = 4'b1010; req_mem = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin req_src = 4'b0100; req_dst = 4'b0110; end
      if (c == 4) req_valid = 1'b0;
      checks++;
      if (bus_sel !== exp_bus[c] || req_ready !== exp_rdy[c]) begin
        errors++;
        $display("FAIL b2b_cycle_%0d got bus_sel=%b ready=%b want bus_sel=%b ready=%b",
                 c, bus_sel, req_ready, exp_bus[c], exp_rdy[c]);
      end
    end
    checks++;
    if (mon_wr !== 2 || mon_done !== 2 || mon_err !== 0) begin
      errors++; $display("FAIL b2b_counts got wr=%0d done=%0d err=%0d want 2 2 0", mon_wr, mon_done, mon_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_read();
    test_mem_timeout();
    test_illegal_dst();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
